// File: rtl/age_ordered_rs.sv
// Age-ordered ALU reservation station: buffers issued ops until both operands are ready,
// wakes them from the CDB ports and dispatches the oldest ready entry (RoB order) to one ALU.
module age_ordered_rs #(
    parameter int RS_BITS  = 3,
    parameter int ROB_BITS = 4,
    parameter int CDB_N    = 2,
    parameter int OP_W     = 6
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [OP_W-1:0]           issue_op,
    input  logic [31:0]               issue_imm,
    input  logic [ROB_BITS-1:0]       issue_dest,
    input  logic                      issue_rdj,
    input  logic [31:0]               issue_vj,
    input  logic [ROB_BITS-1:0]       issue_qj,
    input  logic                      issue_rdk,
    input  logic [31:0]               issue_vk,
    input  logic [ROB_BITS-1:0]       issue_qk,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_BITS-1:0] cdb_id,
    input  logic [CDB_N*32-1:0]       cdb_value,
    input  logic [ROB_BITS-1:0]       rob_head,
    output logic                      alu_valid,
    input  logic                      alu_ready,
    output logic [OP_W-1:0]           alu_op,
    output logic [31:0]               alu_vj,
    output logic [31:0]               alu_vk,
    output logic [31:0]               alu_imm,
    output logic [ROB_BITS-1:0]       alu_dest,
    output logic [RS_BITS:0]          count
);

    localparam int DEPTH = 1 << RS_BITS;

    logic [DEPTH-1:0]    e_valid;
    logic [OP_W-1:0]     e_op   [DEPTH];
    logic [31:0]         e_imm  [DEPTH];
    logic [ROB_BITS-1:0] e_dest [DEPTH];
    logic [DEPTH-1:0]    e_rdj;
    logic [31:0]         e_vj   [DEPTH];
    logic [ROB_BITS-1:0] e_qj   [DEPTH];
    logic [DEPTH-1:0]    e_rdk;
    logic [31:0]         e_vk   [DEPTH];
    logic [ROB_BITS-1:0] e_qk   [DEPTH];

    logic [DEPTH-1:0]    wk_j;
    logic [DEPTH-1:0]    wk_k;
    logic [31:0]         wk_vj  [DEPTH];
    logic [31:0]         wk_vk  [DEPTH];

    logic                fwd_j_hit, fwd_k_hit;
    logic [31:0]         fwd_vj, fwd_vk;
    logic                new_rdj, new_rdk;
    logic [31:0]         new_vj, new_vk;

    logic [RS_BITS-1:0]  alloc_idx;
    logic [RS_BITS-1:0]  sel_idx;
    logic                sel_found;
    logic [ROB_BITS-1:0] sel_age;
    logic [ROB_BITS-1:0] cand_age;
    logic                do_alloc, do_disp;

    // count can only reach DEPTH, so its top bit alone means "full".
    assign issue_ready = rdy_in && !count[RS_BITS];
    assign do_alloc    = issue_valid && issue_ready;
    assign alu_valid   = rdy_in && sel_found;
    assign do_disp     = alu_valid && alu_ready;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        fwd_j_hit = 1'b0;
        fwd_k_hit = 1'b0;
        fwd_vj    = issue_vj;
        fwd_vk    = issue_vk;
        // Scan high to low so the lowest matching port is the one that sticks.
        for (int p = CDB_N - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_id[p*ROB_BITS +: ROB_BITS] == issue_qj) begin
                fwd_j_hit = 1'b1;
                fwd_vj    = cdb_value[p*32 +: 32];
            end
            if (cdb_valid[p] && cdb_id[p*ROB_BITS +: ROB_BITS] == issue_qk) begin
                fwd_k_hit = 1'b1;
                fwd_vk    = cdb_value[p*32 +: 32];
            end
        end
        new_rdj = issue_rdj || fwd_j_hit;
        new_rdk = issue_rdk || fwd_k_hit;
        new_vj  = issue_rdj ? issue_vj : fwd_vj;
        new_vk  = issue_rdk ? issue_vk : fwd_vk;
    end

    always_comb begin
        wk_j = '0;
        wk_k = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wk_vj[i] = e_vj[i];
            wk_vk[i] = e_vk[i];
            for (int p = CDB_N - 1; p >= 0; p--) begin
                if (e_valid[i] && !e_rdj[i] && cdb_valid[p] &&
                    cdb_id[p*ROB_BITS +: ROB_BITS] == e_qj[i]) begin
                    wk_j[i]  = 1'b1;
                    wk_vj[i] = cdb_value[p*32 +: 32];
                end
                if (e_valid[i] && !e_rdk[i] && cdb_valid[p] &&
                    cdb_id[p*ROB_BITS +: ROB_BITS] == e_qk[i]) begin
                    wk_k[i]  = 1'b1;
                    wk_vk[i] = cdb_value[p*32 +: 32];
                end
            end
        end
    end

    // Allocation only looks at registered valid bits, so a slot freed this cycle is reused next cycle.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!e_valid[i]) alloc_idx = RS_BITS'(i);
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '1;
        cand_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cand_age = e_dest[i] - rob_head;
            if (e_valid[i] && e_rdj[i] && e_rdk[i] && (!sel_found || cand_age < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = RS_BITS'(i);
                sel_age   = cand_age;
            end
        end
    end

    assign alu_op   = e_op[sel_idx];
    assign alu_vj   = e_vj[sel_idx];
    assign alu_vk   = e_vk[sel_idx];
    assign alu_imm  = e_imm[sel_idx];
    assign alu_dest = e_dest[sel_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            e_valid <= '0;
            count   <= '0;
        end else if (rdy_in) begin
            if (do_disp)  e_valid[sel_idx]   <= 1'b0;
            if (do_alloc) e_valid[alloc_idx] <= 1'b1;
            case ({do_alloc, do_disp})
                2'b10:   count <= count + {{RS_BITS{1'b0}}, 1'b1};
                2'b01:   count <= count - {{RS_BITS{1'b0}}, 1'b1};
                default: count <= count;
            endcase
        end
    end

    // NOTE: the payload array has no reset; an entry's contents are meaningless until its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush && !rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wk_j[i]) begin
                    e_rdj[i] <= 1'b1;
                    e_vj[i]  <= wk_vj[i];
                end
                if (wk_k[i]) begin
                    e_rdk[i] <= 1'b1;
                    e_vk[i]  <= wk_vk[i];
                end
            end
            // Placed after wakeup so a fresh allocation overrides stale state in the reused slot.
            if (do_alloc) begin
                e_op[alloc_idx]   <= issue_op;
                e_imm[alloc_idx]  <= issue_imm;
                e_dest[alloc_idx] <= issue_dest;
                e_rdj[alloc_idx]  <= new_rdj;
                e_vj[alloc_idx]   <= new_vj;
                e_qj[alloc_idx]   <= issue_qj;
                e_rdk[alloc_idx]  <= new_rdk;
                e_vk[alloc_idx]   <= new_vk;
                e_qk[alloc_idx]   <= issue_qk;
            end
        end
    end

endmodule
